// File: rtl/ifetch_queue.sv
// Instruction fetch: owns the fetch PC, reads instruction memory over req/ack and queues {instr, pc} for decode.
// Optional build macro IFQ_PERF_EN enables the perf_fetched / perf_flushes counters.
module ifetch_queue #(
    parameter int              DEPTH    = 4,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       imem_req,
    output logic [PC_W-1:0]            imem_addr,
    input  logic                       imem_ack,
    input  logic [15:0]                imem_data,
    output logic                       dec_valid,
    input  logic                       dec_ready,
    output logic [15:0]                dec_instr,
    output logic [PC_W-1:0]            dec_pc,
    input  logic                       redir_valid,
    input  logic [PC_W-1:0]            redir_pc,
    output logic [$clog2(DEPTH):0]     q_count,
    output logic [15:0]                perf_fetched,
    output logic [15:0]                perf_flushes
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t          r_state;
    logic [PC_W-1:0] r_fetch_pc;
    logic [PC_W-1:0] r_addr;
    logic            r_req;
    logic [15:0]     r_instr_mem [DEPTH];
    logic [PC_W-1:0] r_pc_mem    [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_next;
    logic            w_room;
    logic [PC_W-1:0] w_pc_inc;

    // A redirect squashes both the returning word and any pop in the same cycle.
    assign w_push       = (r_state == REQ) && imem_ack && !redir_valid;
    assign w_pop        = dec_ready && (r_count != '0) && !redir_valid;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
    assign w_room       = w_count_next < CW'(DEPTH);
    assign w_pc_inc     = r_fetch_pc + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (redir_valid) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wptr] <= imem_data;
            r_pc_mem[r_wptr]    <= r_fetch_pc;
        end
    end

    // Only one request may be outstanding; the room check includes the one about to return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
        end else if (redir_valid) begin
            r_fetch_pc <= redir_pc;
            if ((r_state != IDLE) && !imem_ack) begin
                r_state <= DISCARD;
                r_req   <= 1'b1;
            end else begin
                r_state <= REQ;
                r_req   <= 1'b1;
                r_addr  <= redir_pc;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_room) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                REQ: begin
                    if (imem_ack) begin
                        r_fetch_pc <= w_pc_inc;
                        r_addr     <= w_pc_inc;
                        if (!w_room) begin
                            r_state <= IDLE;
                            r_req   <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        r_state <= REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_fetch_pc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req  = r_req;
    assign imem_addr = r_addr;
    assign q_count   = r_count;
    assign dec_valid = (r_count != '0);
    assign dec_instr = dec_valid ? r_instr_mem[r_rptr] : '0;
    assign dec_pc    = dec_valid ? r_pc_mem[r_rptr]    : '0;

`ifdef IFQ_PERF_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_flushes;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_flushes <= '0;
        end else begin
            if (w_push)      r_perf_fetched <= r_perf_fetched + 16'd1;
            if (redir_valid) r_perf_flushes <= r_perf_flushes + 16'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushes = r_perf_flushes;
`else
    assign perf_fetched = '0;
    assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: in-order fetch table, full/backpressure, redirects, wrap, perf and async reset.
module tb_ifetch_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_instr;
    logic [15:0] dec_pc;
    logic        redir_valid;
    logic [15:0] redir_pc;
    logic [2:0]  q_count;
    logic [15:0] perf_fetched;
    logic [15:0] perf_flushes;

    ifetch_queue dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .q_count(q_count),
        .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_err  = 0;
    int lat    = 1;
    int mcnt   = 0;
    int n_acks = 0;

    typedef struct {
        logic        req;
        logic [15:0] addr;
        logic        vld;
        logic [15:0] pc;
        logic [2:0]  cnt;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: acks the current request after 'lat' idle cycles, data = addr ^ A5A5.
    task automatic mem_tick();
        if (imem_req) begin
            if (mcnt >= lat) begin
                imem_ack  = 1'b1;
                imem_data = imem_addr ^ 16'hA5A5;
                mcnt      = 0;
                n_acks++;
            end else begin
                imem_ack = 1'b0;
                mcnt++;
            end
        end else begin
            imem_ack = 1'b0;
            mcnt     = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        mem_tick();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        dec_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        imem_ack    = 1'b0;
        imem_data   = '0;
        mcnt        = 0;
        n_acks      = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_perf_f;
        logic [15:0] exp_perf_r;
        logic        seen;

        tv[0] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0};
        tv[1] = '{1'b1, 16'h0000, 1'b0, 16'h0000, 3'd0};
        tv[2] = '{1'b1, 16'h0001, 1'b1, 16'h0000, 3'd1};
        tv[3] = '{1'b1, 16'h0001, 1'b0, 16'h0000, 3'd0};
        tv[4] = '{1'b1, 16'h0002, 1'b1, 16'h0001, 3'd1};
        tv[5] = '{1'b1, 16'h0002, 1'b0, 16'h0000, 3'd0};
        tv[6] = '{1'b1, 16'h0003, 1'b1, 16'h0002, 3'd1};
        tv[7] = '{1'b1, 16'h0003, 1'b0, 16'h0000, 3'd0};

        // Reset values
        rst_n = 1'b0; dec_ready = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        imem_ack = 1'b0; imem_data = '0;
        tick();
        chk("reset_outputs", {imem_req, imem_addr, dec_valid, dec_pc, dec_instr, q_count}, 64'h0);
        chk("reset_perf", {perf_fetched, perf_flushes}, 64'h0);

        // In-order fetch, ack one cycle after each request, decode always ready
        do_reset();
        lat       = 1;
        dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("fetch_vec%0d", i),
                {imem_req, imem_addr, dec_valid, dec_pc, dec_instr, q_count},
                {tv[i].req, tv[i].addr, tv[i].vld, tv[i].pc,
                 (tv[i].vld ? (tv[i].pc ^ 16'hA5A5) : 16'h0), tv[i].cnt});
        end

        // Backpressure: exactly DEPTH pushes, then one pop frees one fetch
        do_reset();
        lat = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("full_acks", 64'(n_acks), 64'd4);
        chk("full_state", {imem_req, q_count, dec_pc}, {1'b0, 3'd4, 16'h0000});
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("refill_acks", 64'(n_acks), 64'd5);
        chk("refill_state", {imem_req, q_count, dec_pc}, {1'b0, 3'd4, 16'h0001});

        // Streaming with ack every cycle: push and pop together, occupancy constant
        lat       = 0;
        dec_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("stream%0d", i), {q_count, dec_valid, dec_pc, dec_instr},
                {3'd3, 1'b1, 16'(2 + i), 16'(2 + i) ^ 16'hA5A5});
        end

        // Redirect while ack is delayed: squash the in-flight word
        do_reset();
        lat = 3;
        tick();
        tick();
        redir_valid = 1'b1;
        redir_pc    = 16'h0040;
        tick();
        redir_valid = 1'b0;
        chk("discard_hold", {imem_req, imem_addr, q_count}, {1'b1, 16'h0000, 3'd0});
        tick();
        tick();
        chk("discard_refetch", {imem_req, imem_addr, dec_valid, q_count}, {1'b1, 16'h0040, 1'b0, 3'd0});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (dec_valid) begin
                seen = 1'b1;
                chk("discard_first", {dec_pc, dec_instr}, {16'h0040, 16'hA5E5});
            end
        end
        if (!seen) chk("discard_timeout", 64'd0, 64'd1);

        // Redirect in the same cycle as an ack
        do_reset();
        lat = 0;
        tick();
        redir_valid = 1'b1;
        redir_pc    = 16'h1234;
        tick();
        redir_valid = 1'b0;
        chk("redir_ack_drop", {imem_req, imem_addr, dec_valid, q_count}, {1'b1, 16'h1234, 1'b0, 3'd0});
        tick();
        chk("redir_ack_data", {dec_valid, dec_pc, dec_instr}, {1'b1, 16'h1234, 16'hB791});

        // PC wrap at FFFF
        do_reset();
        lat = 1;
        tick();
        redir_valid = 1'b1;
        redir_pc    = 16'hFFFF;
        tick();
        redir_valid = 1'b0;
        tick();
        chk("wrap_first", {imem_req, imem_addr}, {1'b1, 16'hFFFF});
        tick();
        tick();
        chk("wrap_second", {imem_req, imem_addr, dec_valid, dec_pc, dec_instr},
            {1'b1, 16'h0000, 1'b1, 16'hFFFF, 16'h5A5A});

        // Perf counters: 10 pushes, 2 redirects
        do_reset();
        lat       = 0;
        dec_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (n_acks == 10) begin
                lat = 1000;
                break;
            end
        end
        tick();
        redir_valid = 1'b1;
        redir_pc    = 16'h0100;
        tick();
        tick();
        redir_valid = 1'b0;
        tick();
`ifdef IFQ_PERF_EN
        exp_perf_f = 16'd10;
        exp_perf_r = 16'd2;
`else
        exp_perf_f = 16'd0;
        exp_perf_r = 16'd0;
`endif
        chk("perf_fetched", 64'(perf_fetched), 64'(exp_perf_f));
        chk("perf_flushes", 64'(perf_flushes), 64'(exp_perf_r));

        // Async reset in the middle of a request, then a stray ack
        do_reset();
        lat = 0;
        tick();
        tick();
        tick();
        lat = 1000;
        tick();
        chk("pre_reset_req", {imem_req, imem_addr, q_count}, {1'b1, 16'h0003, 3'd3});
        rst_n = 1'b0;
        #1;
        chk("async_reset_out", {imem_req, imem_addr, dec_valid, dec_pc, dec_instr, q_count}, 64'h0);
        chk("async_reset_perf", {perf_fetched, perf_flushes}, 64'h0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 16'hBEEF;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        chk("stray_ack", {imem_req, imem_addr, dec_valid, q_count}, {1'b1, 16'h0000, 1'b0, 3'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
